qif_neuron_array: RTL and testbench
===================================

# qif_neuron_array

Time-multiplexed array of N quadratic integrate-and-fire (QIF) neurons sharing one saturating datapath. It generalises the single 8-bit QIF neuron with a configurable membrane width and neuron count, a leak term, a configurable threshold and reset potential, and a refractory period. It sits between the synaptic-current inputs (switches or upstream logic) and the spike/membrane observation outputs of the top-level tile. Each enabled clock cycle, one neuron's state is updated in round-robin order.

## Interface
- `WIDTH`, 8: membrane potential and synaptic current width, unsigned.
- `N_NEURONS`, 4: neuron count, ≥2.
- `SQ_SHIFT`, 6: right shift applied to V² for the quadratic term.
- `LEAK`, 1: constant subtracted on every update.
- `V_TH`, 200: spike threshold, ≤ 2^WIDTH−1.
- `V_RESET`, 0: potential loaded on spike and held during refractory.
- `REFRAC`, 2: refractory length, counted in updates of that neuron. 0 disables refractory.

- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `en` input 1: advance/update enable.
- `i_syn` input N_NEURONS*WIDTH: packed synaptic currents. Neuron k uses bits [k*WIDTH +: WIDTH].
- `spike` output N_NEURONS: one-cycle spike pulse per neuron.
- `v_mem` output WIDTH: new potential of the neuron just updated.
- `v_idx` output clog2(N_NEURONS): index of that neuron.
- `v_valid` output 1: `v_mem`/`v_idx` are valid this cycle.

## Operation
- Each neuron has two state fields:
  - V[k], WIDTH bits.
  - R[k], refractory counter, clog2(REFRAC+1) bits (minimum 1).
- Pointer `idx` selects the neuron updated this cycle. When `en`=1 it increments modulo N_NEURONS (N_NEURONS−1 → 0).
- Update of neuron k=idx when `en`=1:
  - If R[k]≠0: V[k] ← V_RESET, R[k] ← R[k]−1, no spike. `i_syn` is ignored.
  - Otherwise, compute:
    - sq = (V·V) >> SQ_SHIFT, using a full 2·WIDTH product.
    - s = V + sq + I − LEAK, evaluated signed with at least 2·WIDTH+2 bits.
    - c = clamp(s, 0, 2^WIDTH−1).
  - If c ≥ V_TH: spike. V[k] ← V_RESET, R[k] ← REFRAC.
  - Otherwise: V[k] ← c.
- Only neuron idx changes in a cycle. All other V/R hold.
- `en`=0: all state and `idx` hold. Outputs `spike`=0 and `v_valid`=0 in the following cycle.
- `rst`=1, which dominates `en`, sets on the next edge:
  - all V=0, all R=0, idx=0;
  - spike=0, v_mem=0, v_idx=0, v_valid=0.
- Reset asserted mid-sequence discards any in-progress refractory and potential.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Update latency is 1 cycle. For an update at edge t (using idx=k and i_syn sampled before edge t), the results are visible after edge t until edge t+1:
  - `spike[k]`=1 if the neuron fired; all other spike bits are 0;
  - `v_mem` = new V[k], which equals V_RESET when spiking;
  - `v_idx`=k, `v_valid`=1.
- `spike` is never high for more than one consecutive cycle on any bit. At most one bit is high per cycle.
- With `en` held high, each neuron is updated every N_NEURONS cycles. The minimum inter-spike interval of one neuron is (REFRAC+1)·N_NEURONS cycles.
- `i_syn` is sampled only for the selected, non-refractory neuron in the cycle of its update. No handshake is used.

## Test plan
All scenarios use default parameters.
- **Reset:** drive `rst`=1 for 2 cycles with arbitrary `i_syn`/`en` → after the first edge, all outputs are 0 and `v_idx`=0. Then release `rst` with `en`=1 → `v_idx` sequence is 0,1,2,3,0.
- **Integration:** neuron 0 with I=10, `en`=1 → successive `v_mem` for idx 0 are 9, then 19 (the quadratic term contributes 1). There are no spikes.
- **Leak floor:** I=0 for all neurons from reset → `v_mem`=0 on every update, never negative or wrapped, and `spike`=0.
- **Spike + refractory:** I0=255, `en`=1 from reset.
  - Update at cycle 0 → c=254 ≥ 200, so `spike[0]`=1 and `v_mem`=0 on the next cycle.
  - Updates at cycles 4 and 8 → `v_mem`=0 and no spike.
  - Update at cycle 12 → spikes again.
- **Saturation / enable gating:** preload V≈250 via I=240 with REFRAC=0 and V_TH=255 → c clamps to 255 and spikes. Then toggle `en` low for 3 cycles → `v_valid`=0, `spike`=0, and `idx` and all V are unchanged.
- **Reset mid-refractory:** assert `rst` for 1 cycle right after the spike in the spike + refractory scenario → the next update of neuron 0 with I=255 spikes immediately, with no refractory delay.

Source files
------------

// File: rtl/qif_neuron_array.sv
// rtl/qif_neuron_array.sv - time-multiplexed array of quadratic integrate-and-fire neurons
//
// One saturating datapath is shared round-robin across N_NEURONS neurons; each
// enabled cycle updates the neuron selected by the internal pointer.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous reset, active-high, dominates en
//   en       - advance/update enable
//   i_syn    - packed synaptic currents, neuron k at [k*WIDTH +: WIDTH]
//   spike    - one-hot, one-cycle spike pulse of the neuron just updated
//   v_mem    - new membrane potential of the neuron just updated
//   v_idx    - index of the neuron just updated
//   v_valid  - v_mem/v_idx carry an update this cycle
module qif_neuron_array #(
    parameter int WIDTH     = 8,
    parameter int N_NEURONS = 4,
    parameter int SQ_SHIFT  = 6,
    parameter int LEAK      = 1,
    parameter int V_TH      = 200,
    parameter int V_RESET   = 0,
    parameter int REFRAC    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [N_NEURONS*WIDTH-1:0]      i_syn,
    output logic [N_NEURONS-1:0]            spike,
    output logic [WIDTH-1:0]                v_mem,
    output logic [$clog2(N_NEURONS)-1:0]    v_idx,
    output logic                            v_valid
);

    localparam int IDX_W = $clog2(N_NEURONS);
    localparam int R_W   = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    // Two guard bits above the 2*WIDTH product: one for the carry of the
    // three-term sum, one for the sign after subtracting the leak.
    localparam int SW    = 2 * WIDTH + 2;

    logic [WIDTH-1:0]       r_v [N_NEURONS];
    logic [R_W-1:0]         r_r [N_NEURONS];
    logic [IDX_W-1:0]       r_idx;

    logic [N_NEURONS-1:0]   r_spike;
    logic [WIDTH-1:0]       r_v_mem;
    logic [IDX_W-1:0]       r_v_idx;
    logic                   r_v_valid;

    logic [WIDTH-1:0]       w_v;
    logic [R_W-1:0]         w_r;
    logic [WIDTH-1:0]       w_i;
    logic [2*WIDTH-1:0]     w_prod;
    logic [2*WIDTH-1:0]     w_sq;
    logic [SW-1:0]          w_sum;
    logic [WIDTH-1:0]       w_clamp;
    logic                   w_refrac;
    logic                   w_fire;
    logic [WIDTH-1:0]       w_v_next;
    logic [IDX_W-1:0]       w_idx_next;

    assign w_v    = r_v[r_idx];
    assign w_r    = r_r[r_idx];
    assign w_i    = i_syn[r_idx*WIDTH +: WIDTH];
    assign w_prod = {{WIDTH{1'b0}}, w_v} * {{WIDTH{1'b0}}, w_v};
    assign w_sq   = w_prod >> SQ_SHIFT;
    assign w_sum  = SW'(w_v) + SW'(w_sq) + SW'(w_i) - SW'(LEAK);

    // Clamp to [0, 2^WIDTH-1]: the MSB is the sign, any set bit between the
    // sign and the membrane field means overflow.
    always_comb begin
        w_clamp = w_sum[WIDTH-1:0];
        if (w_sum[SW-1]) begin
            w_clamp = '0;
        end else if (|w_sum[SW-2:WIDTH]) begin
            w_clamp = '1;
        end
    end

    assign w_refrac   = (w_r != '0);
    assign w_fire     = !w_refrac && (w_clamp >= WIDTH'(V_TH));
    assign w_v_next   = (w_refrac || w_fire) ? WIDTH'(V_RESET) : w_clamp;
    assign w_idx_next = (r_idx == IDX_W'(N_NEURONS - 1)) ? '0 : r_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                r_v[k] <= '0;
                r_r[k] <= '0;
            end
            r_idx     <= '0;
            r_spike   <= '0;
            r_v_mem   <= '0;
            r_v_idx   <= '0;
            r_v_valid <= 1'b0;
        end else if (en) begin
            r_v[r_idx] <= w_v_next;
            if (w_refrac) begin
                r_r[r_idx] <= w_r - R_W'(1);
            end else if (w_fire) begin
                r_r[r_idx] <= R_W'(REFRAC);
            end
            r_idx          <= w_idx_next;
            r_spike        <= '0;
            r_spike[r_idx] <= w_fire;
            r_v_mem        <= w_v_next;
            r_v_idx        <= r_idx;
            r_v_valid      <= 1'b1;
        end else begin
            r_spike   <= '0;
            r_v_valid <= 1'b0;
        end
    end

    assign spike   = r_spike;
    assign v_mem   = r_v_mem;
    assign v_idx   = r_v_idx;
    assign v_valid = r_v_valid;

endmodule

// File: tb/tb_qif_neuron_array.sv
// tb/tb_qif_neuron_array.sv - self-checking bench for qif_neuron_array
module tb_qif_neuron_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] i_syn;

    logic [3:0]  spike_a, spike_b;
    logic [7:0]  v_mem_a, v_mem_b;
    logic [1:0]  v_idx_a, v_idx_b;
    logic        v_valid_a, v_valid_b;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural state for instance 0 (defaults) and 1 (V_TH=255, REFRAC=0)
    int m_v   [2][4];
    int m_r   [2][4];
    int m_idx [2];
    int e_spike [2];
    int e_vmem  [2];
    int e_vidx  [2];
    int e_valid [2];
    bit e_chkv  [2];

    always #5 clk = ~clk;

    qif_neuron_array dut_a (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .i_syn   (i_syn),
        .spike   (spike_a),
        .v_mem   (v_mem_a),
        .v_idx   (v_idx_a),
        .v_valid (v_valid_a)
    );

    qif_neuron_array #(.V_TH(255), .REFRAC(0)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .i_syn   (i_syn),
        .spike   (spike_b),
        .v_mem   (v_mem_b),
        .v_idx   (v_idx_b),
        .v_valid (v_valid_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input int d);
        int th, rf, k, cur, sq, s, c;
        th = (d == 0) ? 200 : 255;
        rf = (d == 0) ? 2 : 0;
        if (rst) begin
            for (int j = 0; j < 4; j++) begin
                m_v[d][j] = 0;
                m_r[d][j] = 0;
            end
            m_idx[d] = 0;
            e_spike[d] = 0; e_vmem[d] = 0; e_vidx[d] = 0; e_valid[d] = 0;
            e_chkv[d] = 1'b1;
        end else if (!en) begin
            e_spike[d] = 0;
            e_valid[d] = 0;
            e_chkv[d]  = 1'b0;
        end else begin
            k = m_idx[d];
            e_spike[d] = 0;
            if (m_r[d][k] > 0) begin
                m_v[d][k] = 0;
                m_r[d][k] = m_r[d][k] - 1;
            end else begin
                cur = int'(i_syn[8*k +: 8]);
                sq  = (m_v[d][k] * m_v[d][k]) / 64;
                s   = m_v[d][k] + sq + cur - 1;
                c   = (s < 0) ? 0 : ((s > 255) ? 255 : s);
                if (c >= th) begin
                    e_spike[d] = 1 << k;
                    m_v[d][k]  = 0;
                    m_r[d][k]  = rf;
                end else begin
                    m_v[d][k] = c;
                end
            end
            e_vmem[d]  = m_v[d][k];
            e_vidx[d]  = k;
            e_valid[d] = 1;
            e_chkv[d]  = 1'b1;
            m_idx[d]   = (k + 1) % 4;
        end
    endtask

    task automatic step();
        model(0);
        model(1);
        @(posedge clk);
        #1;
        chk("a_spike", spike_a, e_spike[0]);
        chk("a_valid", v_valid_a, e_valid[0]);
        chk("b_spike", spike_b, e_spike[1]);
        chk("b_valid", v_valid_b, e_valid[1]);
        if (e_chkv[0]) begin
            chk("a_vmem", v_mem_a, e_vmem[0]);
            chk("a_vidx", v_idx_a, e_vidx[0]);
        end
        if (e_chkv[1]) begin
            chk("b_vmem", v_mem_b, e_vmem[1]);
            chk("b_vidx", v_idx_b, e_vidx[1]);
        end
    endtask

    initial begin
        // Reset with arbitrary inputs
        rst = 1'b1; en = 1'b1; i_syn = $urandom;
        step();
        chk("rst_all_out_a", {spike_a, v_mem_a, v_idx_a, v_valid_a}, 0);
        i_syn = $urandom; en = 1'b0;
        step();

        // Release: index sequence, leak floor with zero current
        rst = 1'b0; en = 1'b1; i_syn = 32'h0;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("idx_seq", v_idx_a, n % 4);
        end
        for (int n = 0; n < 8; n++) begin
            step();
            chk("leak_floor", v_mem_a, 0);
        end

        // Integration
        rst = 1'b1; step(); rst = 1'b0;
        i_syn = 32'h0000_000a;
        step();
        chk("integ_first", v_mem_a, 9);
        for (int n = 0; n < 3; n++) step();
        step();
        chk("integ_second", v_mem_a, 19);
        chk("integ_nospike", spike_a, 0);

        // Spike and refractory
        rst = 1'b1; step(); rst = 1'b0;
        i_syn = 32'h0000_00ff;
        step();
        chk("spk_first", spike_a, 4'b0001);
        chk("spk_first_vmem", v_mem_a, 0);
        for (int n = 1; n < 12; n++) step();
        step();
        chk("spk_again", spike_a, 4'b0001);

        // Reset mid-refractory
        rst = 1'b1; step(); rst = 1'b0;
        step();
        chk("mid_spk", spike_a, 4'b0001);
        rst = 1'b1; step(); rst = 1'b0;
        step();
        chk("mid_no_refrac", spike_a, 4'b0001);

        // Saturation on the REFRAC=0 / V_TH=255 instance, then enable gating
        rst = 1'b1; step(); rst = 1'b0;
        i_syn = 32'h0000_00f0;
        step();
        chk("sat_first", v_mem_b, 239);
        for (int n = 0; n < 3; n++) step();
        step();
        chk("sat_spike", spike_b, 4'b0001);
        en = 1'b0;
        for (int n = 0; n < 3; n++) begin
            i_syn = $urandom;
            step();
            chk("gate_valid", v_valid_b, 0);
        end
        en = 1'b1; i_syn = 32'h0000_00f0;
        step();
        chk("gate_idx_resume", v_idx_b, 1);
        for (int n = 0; n < 7; n++) step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 99) < 2);
            en    = ($urandom_range(0, 99) < 80);
            i_syn = $urandom;
            if ($urandom_range(0, 3) == 0) i_syn = i_syn & 32'h1f1f_1f1f;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
